// File: rtl/ldpc_err_stats_pkg.sv
// LDPC error statistics shared package.
// FSM state encoding and scan-length constant/helper.
package ldpc_err_stats_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SCAN,
    ST_DONE
  } state_t;

  localparam int DEF_DIM   = 2304;
  localparam int DEF_CHUNK = 96;

  function automatic int scan_cycles(
    input int dim,
    input int chunk
  );
    return dim / chunk;
  endfunction

  localparam int SCAN_CYC =
    scan_cycles(DEF_DIM, DEF_CHUNK);

endpackage

// File: rtl/ldpc_err_stats_popcnt.sv
// Combinational popcount of CHUNK bits as a balanced adder tree.
// Ports: bits (CHUNK) in, cnt (clog2(CHUNK+1)) out.
module popcnt #(
  parameter int CHUNK = 96
) (
  input  logic [CHUNK-1:0]         bits,
  output logic [$clog2(CHUNK+1)-1:0] cnt
);

  localparam int OW = $clog2(CHUNK + 1);
  localparam int LV = $clog2(CHUNK);
  localparam int N  = 1 << LV;

  // Level 0 holds the (zero-padded) leaves; each
  // further level sums adjacent pairs of the one below.
  for (genvar l = 0; l <= LV; l++) begin : lv
    localparam int W = N >> l;
    logic [OW-1:0] s [W];
    for (genvar i = 0; i < W; i++) begin : nd
      if (l == 0) begin : leaf
        if (i < CHUNK) begin : used
          assign s[i] = OW'(bits[i]);
        end else begin : pad
          assign s[i] = '0;
        end
      end else begin : sum
        assign s[i] = lv[l-1].s[2*i]
                    + lv[l-1].s[2*i+1];
      end
    end
  end

  assign cnt = lv[LV].s[0];

endmodule

// File: rtl/ldpc_err_stats.sv
// LDPC decoder error statistics: counts frames, FER, BER, undetected.
// Ports: start/frames_target run control, frame_vld/res/frame_err in, frame_rdy/busy/done/counters out.
module ldpc_err_stats #(
  parameter int DIM   = 2304,
  parameter int CHUNK = 96,
  parameter int FRM_W = 16,
  parameter int BIT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [FRM_W-1:0] frames_target,
  input  logic             frame_vld,
  input  logic [DIM-1:0]   res,
  input  logic             frame_err,
  output logic             frame_rdy,
  output logic             busy,
  output logic             done,
  output logic [FRM_W-1:0] frm_cnt,
  output logic [FRM_W-1:0] fer_cnt,
  output logic [BIT_W-1:0] ber_cnt,
  output logic [FRM_W-1:0] undet_cnt
);

  import ldpc_err_stats_pkg::*;

  localparam int NSCAN = scan_cycles(DIM, CHUNK);
  localparam int SC_W  = $clog2(NSCAN + 1);
  localparam int PC_W  = $clog2(CHUNK + 1);

  state_t           st;
  logic [FRM_W-1:0] target;
  logic [DIM-1:0]   sreg;
  logic             ferr_q;
  logic             flag;
  logic [SC_W-1:0]  scnt;

  logic [PC_W-1:0]  pc;
  logic [BIT_W:0]   ber_sum;
  logic [BIT_W-1:0] ber_nxt;
  logic [FRM_W-1:0] frm_nxt;
  logic             hit;
  logic             last;

  popcnt #(
    .CHUNK(CHUNK)
  ) u_popcnt (
    .bits(sreg[CHUNK-1:0]),
    .cnt (pc)
  );

  assign hit  = (pc != '0);
  assign last = (scnt == SC_W'(NSCAN - 1));

  // One extra carry bit detects BIT_W overflow.
  assign ber_sum = {1'b0, ber_cnt}
                 + (BIT_W+1)'(pc);
  assign ber_nxt = ber_sum[BIT_W] ? '1
                 : ber_sum[BIT_W-1:0];

  assign frm_nxt = (&frm_cnt) ? frm_cnt
                 : frm_cnt + FRM_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_IDLE;
      target    <= '0;
      sreg      <= '0;
      ferr_q    <= 1'b0;
      flag      <= 1'b0;
      scnt      <= '0;
      frm_cnt   <= '0;
      fer_cnt   <= '0;
      ber_cnt   <= '0;
      undet_cnt <= '0;
      frame_rdy <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (st)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            frm_cnt   <= '0;
            fer_cnt   <= '0;
            ber_cnt   <= '0;
            undet_cnt <= '0;
            target    <= frames_target;
            if (frames_target == '0) begin
              st        <= ST_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              frame_rdy <= 1'b0;
            end else begin
              st        <= ST_WAIT;
              busy      <= 1'b1;
              done      <= 1'b0;
              frame_rdy <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (frame_vld) begin
            sreg      <= res;
            ferr_q    <= frame_err;
            flag      <= 1'b0;
            scnt      <= '0;
            st        <= ST_SCAN;
            frame_rdy <= 1'b0;
            if (frame_err && !(&fer_cnt))
              fer_cnt <= fer_cnt + FRM_W'(1);
          end
        end
        ST_SCAN: begin
          ber_cnt <= ber_nxt;
          sreg    <= sreg >> CHUNK;
          if (hit)
            flag <= 1'b1;
          if (last) begin
            frm_cnt <= frm_nxt;
            if (!ferr_q && (flag || hit)
                && !(&undet_cnt))
              undet_cnt <= undet_cnt + FRM_W'(1);
            if (frm_nxt == target) begin
              st   <= ST_DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              st        <= ST_WAIT;
              frame_rdy <= 1'b1;
            end
          end else begin
            scnt <= scnt + SC_W'(1);
          end
        end
        default: begin
          st        <= ST_IDLE;
          frame_rdy <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_err_stats.sv
// Bench for ldpc_err_stats: randomized frames vs a frame-level model.
// Narrow BIT_W so ber_cnt saturation is reachable.
module tb_ldpc_err_stats;

  localparam int DIM   = 2304;
  localparam int CHUNK = 96;
  localparam int FRM_W = 16;
  localparam int BIT_W = 12;
  localparam int NSCAN = DIM / CHUNK;
  localparam int BMAX  = (1 << BIT_W) - 1;
  localparam int FMAX  = (1 << FRM_W) - 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic [FRM_W-1:0] frames_target;
  logic             frame_vld;
  logic [DIM-1:0]   res;
  logic             frame_err;
  logic             frame_rdy;
  logic             busy;
  logic             done;
  logic [FRM_W-1:0] frm_cnt;
  logic [FRM_W-1:0] fer_cnt;
  logic [BIT_W-1:0] ber_cnt;
  logic [FRM_W-1:0] undet_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ldpc_err_stats #(
    .DIM  (DIM),
    .CHUNK(CHUNK),
    .FRM_W(FRM_W),
    .BIT_W(BIT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .frames_target(frames_target),
    .frame_vld    (frame_vld),
    .res          (res),
    .frame_err    (frame_err),
    .frame_rdy    (frame_rdy),
    .busy         (busy),
    .done         (done),
    .frm_cnt      (frm_cnt),
    .fer_cnt      (fer_cnt),
    .ber_cnt      (ber_cnt),
    .undet_cnt    (undet_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int sat_b(input int v);
    return (v > BMAX) ? BMAX : v;
  endfunction

  function automatic int sat_f(input int v);
    return (v > FMAX) ? FMAX : v;
  endfunction

  // Low k chunks of v, everything above cleared.
  function automatic logic [DIM-1:0] low_part(
    input logic [DIM-1:0] v,
    input int             k
  );
    logic [DIM-1:0] m;
    m = '1;
    m = m << (k * CHUNK);
    return v & ~m;
  endfunction

  // Frame-level model: phase 0 idle, 1 wait, 2 scan, 3 done.
  int             m_mode  = 0;
  int             m_tgt   = 0;
  int             m_frm   = 0;
  int             m_fer   = 0;
  int             m_undet = 0;
  int             m_ber   = 0;
  int             m_base  = 0;
  int             m_left  = 0;
  logic [DIM-1:0] m_cur   = '0;
  logic           m_err   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode  <= 0;
      m_frm   <= 0;
      m_fer   <= 0;
      m_undet <= 0;
      m_ber   <= 0;
      m_left  <= 0;
    end else begin
      case (m_mode)
        0, 3: if (start) begin
          m_frm   <= 0;
          m_fer   <= 0;
          m_undet <= 0;
          m_ber   <= 0;
          m_tgt   <= int'(frames_target);
          m_mode  <= (frames_target == '0) ? 3 : 1;
        end
        1: if (frame_vld) begin
          m_cur  <= res;
          m_err  <= frame_err;
          m_base <= m_ber;
          m_fer  <= sat_f(m_fer + int'(frame_err));
          m_left <= NSCAN;
          m_mode <= 2;
        end
        2: begin
          m_left <= m_left - 1;
          m_ber  <= sat_b(m_base + $countones(
                      low_part(m_cur, NSCAN - m_left + 1)));
          if (m_left == 1) begin
            m_frm <= sat_f(m_frm + 1);
            if (!m_err && $countones(m_cur) != 0)
              m_undet <= sat_f(m_undet + 1);
            m_mode <= (sat_f(m_frm + 1) == m_tgt) ? 3 : 1;
          end
        end
        default: m_mode <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("frame_rdy", 64'(frame_rdy), 64'(m_mode == 1));
    chk("busy", 64'(busy),
        64'(m_mode == 1 || m_mode == 2));
    chk("done", 64'(done), 64'(m_mode == 3));
    chk("frm_cnt", 64'(frm_cnt), 64'(m_frm));
    chk("fer_cnt", 64'(fer_cnt), 64'(m_fer));
    chk("ber_cnt", 64'(ber_cnt), 64'(m_ber));
    chk("undet_cnt", 64'(undet_cnt), 64'(m_undet));
  end

  function automatic logic [DIM-1:0] rand_res(
    input int kind
  );
    logic [DIM-1:0] v;
    v = '0;
    case (kind)
      1: begin
        int n;
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++)
          v[$urandom_range(0, DIM - 1)] = 1'b1;
      end
      2: for (int i = 0; i < DIM / 32; i++)
        v[i*32 +: 32] = $urandom;
      3: v = '1;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic do_start(input int t);
    start         = 1'b1;
    frames_target = FRM_W'(t);
    @(negedge clk);
    start         = 1'b0;
    frames_target = FRM_W'($urandom);
  endtask

  task automatic send(
    input logic [DIM-1:0] r,
    input logic           e
  );
    int n;
    n = 0;
    while (!frame_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_wait", 64'(frame_rdy), 64'd1);
    frame_vld = 1'b1;
    res       = r;
    frame_err = e;
    @(negedge clk);
    frame_vld = 1'b0;
    res       = rand_res(2);
    frame_err = 1'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", 64'(done), 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"}, 64'(frame_rdy), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_frm"}, 64'(frm_cnt), 64'd0);
    chk({tag, "_fer"}, 64'(fer_cnt), 64'd0);
    chk({tag, "_ber"}, 64'(ber_cnt), 64'd0);
    chk({tag, "_undet"}, 64'(undet_cnt), 64'd0);
  endtask

  initial begin
    logic [DIM-1:0] r;
    int n;
    rst           = 1'b1;
    start         = 1'b0;
    frames_target = '0;
    frame_vld     = 1'b0;
    res           = '0;
    frame_err     = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Three clean frames; done exactly after 24 scan cycles.
    do_start(3);
    send('0, 1'b0);
    send('0, 1'b0);
    send('0, 1'b0);
    for (int i = 0; i < NSCAN; i++) begin
      chk("done_early", 64'(done), 64'd0);
      @(negedge clk);
    end
    chk("done_time", 64'(done), 64'd1);
    chk("t3_frm", 64'(frm_cnt), 64'd3);
    chk("t3_fer", 64'(fer_cnt), 64'd0);
    chk("t3_ber", 64'(ber_cnt), 64'd0);
    chk("t3_undet", 64'(undet_cnt), 64'd0);

    // Chunk-boundary bits, undetected frame.
    r = '0;
    r[0]    = 1'b1;
    r[95]   = 1'b1;
    r[96]   = 1'b1;
    r[2303] = 1'b1;
    do_start(1);
    send(r, 1'b0);
    wait_done();
    chk("b4_ber", 64'(ber_cnt), 64'd4);
    chk("b4_undet", 64'(undet_cnt), 64'd1);
    chk("b4_fer", 64'(fer_cnt), 64'd0);

    // All-ones detected frame then clean frame.
    do_start(2);
    send('1, 1'b1);
    send('0, 1'b0);
    wait_done();
    chk("ones_ber", 64'(ber_cnt), 64'd2304);
    chk("ones_fer", 64'(fer_cnt), 64'd1);
    chk("ones_undet", 64'(undet_cnt), 64'd0);
    chk("ones_frm", 64'(frm_cnt), 64'd2);

    // Two all-ones undetected frames overflow BIT_W.
    do_start(2);
    send('1, 1'b0);
    send('1, 1'b0);
    wait_done();
    chk("sat_ber", 64'(ber_cnt), 64'(BMAX));
    chk("sat_undet", 64'(undet_cnt), 64'd2);

    // frame_vld held high: one capture per WAIT visit.
    do_start(2);
    frame_vld = 1'b1;
    res       = rand_res(1);
    frame_err = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_rdy && n < 50);
    while (!frame_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_gap", 64'(n), 64'd25);
    wait_done();
    frame_vld = 1'b0;
    chk("hold_fer", 64'(fer_cnt), 64'd2);
    chk("hold_frm", 64'(frm_cnt), 64'd2);

    // Reset mid-scan, then a fresh run.
    do_start(1);
    send(rand_res(2), 1'b0);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    r = '0;
    while ($countones(r) < 5)
      r[$urandom_range(0, DIM - 1)] = 1'b1;
    do_start(1);
    send(r, 1'b0);
    wait_done();
    chk("rst_ber", 64'(ber_cnt), 64'd5);

    // Zero target finishes immediately with cleared counters.
    do_start(0);
    chk("t0_done", 64'(done), 64'd1);
    chk("t0_ber", 64'(ber_cnt), 64'd0);
    chk("t0_frm", 64'(frm_cnt), 64'd0);

    // start during SCAN is ignored.
    do_start(1);
    send(rand_res(1), 1'b1);
    repeat (5) @(negedge clk);
    do_start(7);
    wait_done();
    chk("ign_frm", 64'(frm_cnt), 64'd1);
    chk("ign_fer", 64'(fer_cnt), 64'd1);

    // Randomized runs with stray start/frame_vld pulses.
    for (int run = 0; run < 8; run++) begin
      int t;
      t = $urandom_range(1, 4);
      do_start(t);
      for (int f = 0; f < t; f++) begin
        repeat ($urandom_range(0, 3)) begin
          start = 1'($urandom);
          @(negedge clk);
          start = 1'b0;
        end
        send(rand_res($urandom_range(0, 3)),
             1'($urandom));
        if ($urandom_range(0, 1) == 1) begin
          frame_vld = 1'b1;
          @(negedge clk);
          frame_vld = 1'b0;
        end
      end
      wait_done();
      chk("rnd_frm", 64'(frm_cnt), 64'(t));
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ldpc_err_stats.md
LDPC_ERR_STATS -- requirements
Module: ldpc_err_stats

Interface
REQ-001 Parameter DIM, default 2304: decoded codeword length in bits (R*D).
REQ-002 Parameter CHUNK, default 96: bits scanned per cycle; DIM SHALL be an integer multiple of CHUNK.
REQ-003 Parameter FRM_W, default 16: frame-counter width.
REQ-004 Parameter BIT_W, default 32: bit-error-counter width.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  one-cycle pulse that begins a measurement run.
REQ-008 frames_target  input  FRM_W  frames per run, sampled on start.
REQ-009 frame_vld  input  1  decoder finished a frame; res and frame_err are valid.
REQ-010 res  input  DIM  hard-decision codeword; all-zero codeword transmitted, so each 1 is a bit error.
REQ-011 frame_err  input  1  decoder reports parity failure for this frame.
REQ-012 frame_rdy  output  1  block can accept a frame this cycle.
REQ-013 busy  output  1  run in progress.
REQ-014 done  output  1  run complete; counters stable.
REQ-015 frm_cnt  output  FRM_W  frames accepted and fully scanned.
REQ-016 fer_cnt  output  FRM_W  frames with frame_err=1.
REQ-017 ber_cnt  output  BIT_W  total bit errors.
REQ-018 undet_cnt  output  FRM_W  frames with frame_err=0 but at least one bit error.

Function
REQ-019 FSM states: IDLE, WAIT, SCAN, DONE.
REQ-020 IDLE/DONE + start: clear all counters, latch frames_target, go to WAIT; if frames_target=0, go to DONE instead.
REQ-021 WAIT: frame_rdy=1; frame_vld=1 captures res into a DIM-bit shift register, latches frame_err, adds frame_err to fer_cnt, clears the per-frame error flag, and goes to SCAN.
REQ-022 SCAN: frame_rdy=0; each cycle add the popcount of the low CHUNK bits to ber_cnt, shift the register right by CHUNK, and set the per-frame flag if the popcount is nonzero; exactly DIM/CHUNK cycles (24 at defaults).
REQ-023 Last SCAN cycle: frm_cnt+1, and undet_cnt+1 if latched frame_err=0 and the flag (including this chunk) is set; then go to DONE if the new frm_cnt equals target, else WAIT.
REQ-024 Frame-to-frame throughput: 1 capture cycle + DIM/CHUNK scan cycles; done rises the cycle after the final scan cycle.
REQ-025 frame_vld while frame_rdy=0 SHALL be ignored with no counter change; the upstream holds frame_vld until it sees frame_rdy.
REQ-026 start in WAIT or SCAN SHALL be ignored.
REQ-027 All counters saturate at all-ones; ber_cnt adds use a CHUNK-sized popcount zero-extended to BIT_W.
REQ-028 busy=1 in WAIT and SCAN; done=1 only in DONE; counters hold in DONE until the next start.
REQ-029 Popcount SHALL be a combinational adder tree in one cycle; no other pipelining.

Reset
REQ-030 rst SHALL force IDLE, all counters 0, the shift register 0, frame_rdy=0, busy=0, done=0, asynchronously and at any point, including mid-SCAN; the partial frame is discarded.

Structure
REQ-031 The state encoding and the DIM/CHUNK scan-count constant belong in the shared LDPC package.
REQ-032 One sub-module, popcnt (parameter CHUNK, output of width clog2(CHUNK+1)), is instantiated once.

Verification
REQ-033 Target=3 with three all-zero frames, frame_err=0 -> frm_cnt=3, fer_cnt=0, ber_cnt=0, undet_cnt=0, done one cycle after the 3rd frame's 24th scan cycle.
REQ-034 Target=1 with res having bits 0, 95, 96 and 2303 set, frame_err=0 -> ber_cnt=4, undet_cnt=1, fer_cnt=0.
REQ-035 Target=2 with frame 1 all-ones and frame_err=1, then frame 2 all-zero -> ber_cnt=2304, fer_cnt=1, undet_cnt=0, frm_cnt=2.
REQ-036 frame_vld held high through SCAN -> exactly one capture per WAIT visit; with target=2, the second capture occurs 25 cycles after the first.
REQ-037 rst asserted at scan cycle 10 of frame 1 -> all outputs 0 the same cycle; a new start with target=1 and res of 5 ones gives ber_cnt=5.
REQ-038 Target=0 start -> done the next cycle, all counters 0; start during SCAN -> ignored, counters unaffected.
